axi_lite_sram_frontend: RTL
===========================

Name: axi_lite_sram_frontend

Overview:
AXI4-Lite slave front end in the AXI clock domain, directly upstream of the SRAM controller's request FIFOs and downstream of its response FIFOs. It accepts AW/W/AR handshakes and pushes byte-to-word converted addresses and {strobe,data} words into the write sides of the aw/w/ar FIFOs. It pops the b/r FIFOs (first-word-fall-through) into registered B/R output stages, and it limits outstanding transactions per direction.

Parameters:
AXI_ADDR_WIDTH, 32, AXI byte address width
SRAM_DATA_WIDTH, 32, data width (multiple of 8, power of 2); strobe width = SRAM_DATA_WIDTH/8
MAX_OUTSTANDING, 4, maximum accepted-but-unresponded transactions per direction (>=1)

Ports:
axi_clk  in  1  clock; all logic on rising edge
axi_rst_n  in  1  asynchronous active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  AXI_ADDR_WIDTH/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  SRAM_DATA_WIDTH/SRAM_DATA_WIDTH/8/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axi_araddr/arvalid/arready  in/in/out  AXI_ADDR_WIDTH/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  SRAM_DATA_WIDTH/2/1/1  read data channel
aw_fifo_wdata/wen/full  out/out/in  AXI_ADDR_WIDTH/1/1  write-address FIFO write side
w_fifo_wdata/wen/full  out/out/in  SRAM_DATA_WIDTH+SRAM_DATA_WIDTH/8/1/1  write-data FIFO write side, {wstrb,wdata}
ar_fifo_wdata/wen/full  out/out/in  AXI_ADDR_WIDTH/1/1  read-address FIFO write side
r_fifo_rdata/ren/empty  in/out/in  SRAM_DATA_WIDTH/1/1  read-data FIFO read side (FWFT)
b_fifo_rdata/ren/empty  in/out/in  2/1/1  write-response FIFO read side (FWFT)
wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  status: outstanding writes
rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  status: outstanding reads

Behaviour:
- Reset (async assert, sync use after deassert): bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, both counters 0. All FIFO wen/ren are 0 while axi_rst_n=0. Ready outputs are 0 while in reset.
- Address conversion: fifo address = axi address >> $clog2(SRAM_DATA_WIDTH/8), zero-filled at the top (0x0000_0010 -> 0x0000_0004 at 32-bit). Low offset bits are discarded.
- AW: awready = !aw_fifo_full && wr_outstanding<MAX_OUTSTANDING (combinational). aw_fifo_wen = awvalid&&awready. No latency; push occurs in the handshake cycle.
- W: wready = !w_fifo_full. w_fifo_wen = wvalid&&wready. wdata = {wstrb,wdata}. W is independent of AW; ordering is preserved by the FIFOs.
- AR: arready = !ar_fifo_full && rd_outstanding<MAX_OUTSTANDING. ar_fifo_wen = arvalid&&arready.
- B stage (1-entry register): b_fifo_ren = !b_fifo_empty && (!bvalid || bready).
  - On pop: bresp<=b_fifo_rdata, bvalid<=1.
  - On bvalid&&bready with no pop: bvalid<=0.
  - Back-to-back responses at full throughput (one per cycle).
- R stage: identical structure. rdata<=r_fifo_rdata, rresp<=2'b00.
- bresp/rdata hold stable while valid&&!ready (AXI stability).
- Counters:
  - wr_outstanding +1 on AW handshake, -1 on B handshake; both in the same cycle -> unchanged.
  - rd_outstanding is the same using AR/R handshakes.
  - Counters never exceed MAX_OUTSTANDING and never underflow. A B/R handshake at count 0 is an assertion error.
- Full counter blocks AW/AR even if the FIFO has space. A decrement in the same cycle does not open ready; ready reopens the next cycle.
- Simultaneous AW, W and AR handshakes in one cycle are all legal and independent.
- Reset mid-operation: valid outputs drop immediately, counters clear, and nothing held in the output registers is re-emitted.

Test Plan:
- Single write: awaddr=0x0000_0010, wdata=0xDEADBEEF, wstrb=0xF, then b_fifo supplies 2'b00 -> aw_fifo_wdata=0x4, w_fifo_wdata=0xF_DEADBEEF, bvalid one cycle after b_fifo_ren, bresp=00, wr_outstanding goes 1 then 0.
- Single read: araddr=0x20, r_fifo supplies 0x12345678 -> ar_fifo_wdata=0x8, rvalid with rdata=0x12345678, rresp=00.
- Outstanding limit: 5 AR issued with rready=0 and r_fifo empty -> arready=0 after the 4th, rd_outstanding=4. One R handshake -> arready returns the following cycle.
- Back-pressure: hold bready=0 with 3 entries in b_fifo -> one pop only, bresp stable. Then bready=1 -> 3 responses on consecutive cycles.
- FIFO full: aw_fifo_full=1 -> awready=0 and no aw_fifo_wen. w_fifo_full=1 -> wready=0. AR is unaffected in both cases.
- Reset mid-burst: assert axi_rst_n=0 while rvalid=1 and the counters are non-zero -> rvalid=0 and counters=0 immediately, and no FIFO strobes during reset.

Source files
------------

// File: rtl/axi_lite_sram_frontend.sv
// ---------------------------------------------------------------------------
// axi_lite_sram_frontend
//
// AXI4-Lite slave front end for an SRAM controller. It sits in the AXI clock
// domain, between the AXI bus and the controller's request and response FIFOs.
//
// Request path:
//   AW, W and AR handshakes are pushed straight into the aw/w/ar FIFOs in the
//   handshake cycle itself. Addresses are converted from byte addresses to
//   word addresses on the way in.
//
// Response path:
//   The b/r FIFOs are first-word-fall-through. They are popped into one-entry
//   registered B/R output stages that sustain one response per cycle.
//
// Outstanding transactions are counted per direction and capped at
// MAX_OUTSTANDING.
//
// Ports:
//   axi_clk, axi_rst_n        clock, asynchronous active-low reset
//   s_axi_aw*                 write address channel
//   s_axi_w*                  write data channel
//   s_axi_b*                  write response channel (registered)
//   s_axi_ar*                 read address channel
//   s_axi_r*                  read data channel (registered)
//   aw_fifo_*                 write-address FIFO push side (word address)
//   w_fifo_*                  write-data FIFO push side, {wstrb, wdata}
//   ar_fifo_*                 read-address FIFO push side (word address)
//   r_fifo_*                  read-data FIFO pop side (FWFT)
//   b_fifo_*                  write-response FIFO pop side (FWFT)
//   wr_outstanding            outstanding-write count
//   rd_outstanding            outstanding-read count
// ---------------------------------------------------------------------------
module axi_lite_sram_frontend #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                           axi_clk,
  input  logic                                           axi_rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]                      s_axi_awaddr,
  input  logic                                           s_axi_awvalid,
  output logic                                           s_axi_awready,
  input  logic [SRAM_DATA_WIDTH-1:0]                     s_axi_wdata,
  input  logic [SRAM_DATA_WIDTH/8-1:0]                   s_axi_wstrb,
  input  logic                                           s_axi_wvalid,
  output logic                                           s_axi_wready,
  output logic [1:0]                                     s_axi_bresp,
  output logic                                           s_axi_bvalid,
  input  logic                                           s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]                      s_axi_araddr,
  input  logic                                           s_axi_arvalid,
  output logic                                           s_axi_arready,
  output logic [SRAM_DATA_WIDTH-1:0]                     s_axi_rdata,
  output logic [1:0]                                     s_axi_rresp,
  output logic                                           s_axi_rvalid,
  input  logic                                           s_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]                      aw_fifo_wdata,
  output logic                                           aw_fifo_wen,
  input  logic                                           aw_fifo_full,
  output logic [SRAM_DATA_WIDTH+SRAM_DATA_WIDTH/8-1:0]   w_fifo_wdata,
  output logic                                           w_fifo_wen,
  input  logic                                           w_fifo_full,
  output logic [AXI_ADDR_WIDTH-1:0]                      ar_fifo_wdata,
  output logic                                           ar_fifo_wen,
  input  logic                                           ar_fifo_full,
  input  logic [SRAM_DATA_WIDTH-1:0]                     r_fifo_rdata,
  output logic                                           r_fifo_ren,
  input  logic                                           r_fifo_empty,
  input  logic [1:0]                                     b_fifo_rdata,
  output logic                                           b_fifo_ren,
  input  logic                                           b_fifo_empty,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]           wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]           rd_outstanding
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int              OFF     = $clog2(SRAM_DATA_WIDTH / 8);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_rvalid;
  logic [SRAM_DATA_WIDTH-1:0] r_rdata;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  logic w_aw_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;

  // ---------------------------------------------------------------------------
  // Request channels.
  // Ready is qualified with reset so that nothing is pushed while in reset.
  // The count limit is taken from the registered count. A response that
  // retires in the same cycle therefore reopens ready only on the following
  // cycle; this keeps the path from bready/rready to awready/arready free of
  // combinational logic.
  // ---------------------------------------------------------------------------
  assign s_axi_awready = axi_rst_n && !aw_fifo_full && (r_wr_cnt < MAX_CNT);
  assign s_axi_wready  = axi_rst_n && !w_fifo_full;
  assign s_axi_arready = axi_rst_n && !ar_fifo_full && (r_rd_cnt < MAX_CNT);

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;

  assign aw_fifo_wen   = w_aw_hs;
  assign aw_fifo_wdata = s_axi_awaddr >> OFF;
  assign w_fifo_wen    = s_axi_wvalid && s_axi_wready;
  assign w_fifo_wdata  = {s_axi_wstrb, s_axi_wdata};
  assign ar_fifo_wen   = w_ar_hs;
  assign ar_fifo_wdata = s_axi_araddr >> OFF;

  // ---------------------------------------------------------------------------
  // Response stages.
  // A stage pops whenever it is empty or is being drained this cycle, which
  // gives one response per cycle.
  // ---------------------------------------------------------------------------
  assign w_b_hs     = r_bvalid && s_axi_bready;
  assign w_r_hs     = r_rvalid && s_axi_rready;
  assign b_fifo_ren = axi_rst_n && !b_fifo_empty && (!r_bvalid || s_axi_bready);
  assign r_fifo_ren = axi_rst_n && !r_fifo_empty && (!r_rvalid || s_axi_rready);

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (b_fifo_ren) begin
      r_bvalid <= 1'b1;
      r_bresp  <= b_fifo_rdata;
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (r_fifo_ren) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_fifo_rdata;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  // The SRAM read path has no error source, so every read is OKAY.
  assign s_axi_rresp  = 2'b00;

  // ---------------------------------------------------------------------------
  // Outstanding counters.
  // An accept and a retire in the same cycle cancel out. The guard at zero
  // keeps the count from wrapping if a protocol error ever occurs; such an
  // error is also flagged by the assertions below.
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_wr_cnt <= '0;
    end else begin
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_wr_cnt <= r_wr_cnt + 1'b1;
        2'b01:   if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - 1'b1;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      r_rd_cnt <= '0;
    end else begin
      case ({w_ar_hs, w_r_hs})
        2'b10:   r_rd_cnt <= r_rd_cnt + 1'b1;
        2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - 1'b1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  assign wr_outstanding = r_wr_cnt;
  assign rd_outstanding = r_rd_cnt;

  // A response with nothing outstanding means the downstream FIFOs are out of
  // step with the request stream.
  a_no_b_underflow: assert property (@(posedge axi_clk) disable iff (!axi_rst_n)
    !(w_b_hs && r_wr_cnt == '0));
  a_no_r_underflow: assert property (@(posedge axi_clk) disable iff (!axi_rst_n)
    !(w_r_hs && r_rd_cnt == '0));

endmodule
